level_ctrl: RTL and testbench

Game-progress controller sitting directly upstream of the start/finish screen overlay stage. It owns the start-screen handshake (`game_started`) and the current screen index (`level`), both of which the overlay stage and the background/player drawing stages consume. Level transitions are evaluated once per video frame from the player's vertical position. Each transition emits a one-cycle wrap pulse so the physics block can relocate the player to the opposite screen edge.

---
 rtl/level_ctrl.sv | 121 ++++++++++++
 tb/tb_level_ctrl.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/level_ctrl.sv
// Game-progress controller: start-screen handshake, per-frame level transitions with holdoff.
// Optional debug skip input is enabled by defining LEVEL_DEBUG_EN.
module level_ctrl #(
   parameter int TOP_THRESH     = 4,
   parameter int BOT_THRESH     = 760,
   parameter int MAX_LEVEL      = 3,
   parameter int HOLDOFF_FRAMES = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        vsync_in,
   input  logic        start_btn,
`ifdef LEVEL_DEBUG_EN
   input  logic        dbg_skip,
`endif
   input  logic [11:0] y_value,
   output logic [1:0]  level,
   output logic        game_started,
   output logic        wrap_top,
   output logic        wrap_bottom,
   output logic        frame_tick
);

   localparam int CW = (HOLDOFF_FRAMES > 0) ? $clog2(HOLDOFF_FRAMES + 1) : 1;
   localparam logic [1:0]    MAXL    = 2'(MAX_LEVEL);
   localparam logic [11:0]   TOP     = 12'(TOP_THRESH);
   localparam logic [11:0]   BOT     = 12'(BOT_THRESH);
   localparam logic [CW-1:0] HOLD_LD = CW'(HOLDOFF_FRAMES);

   typedef enum logic [1:0] {IDLE, ARMED, PLAY, HOLD} state_t;

   state_t        state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic [1:0]    level_n;
   logic          started_n, wt_n, wb_n;
   logic          vsync_q;
   logic          tick;

   assign tick = vsync_in & ~vsync_q;

`ifdef LEVEL_DEBUG_EN
   logic dbg_q;
   logic skip_rise;
   assign skip_rise = dbg_skip & ~dbg_q;
   always_ff @(posedge clk) begin
      if (rst) dbg_q <= 1'b0;
      else     dbg_q <= dbg_skip;
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         cnt          <= '0;
         vsync_q      <= 1'b0;
         frame_tick   <= 1'b0;
         level        <= '0;
         game_started <= 1'b0;
         wrap_top     <= 1'b0;
         wrap_bottom  <= 1'b0;
      end else begin
         state        <= state_n;
         cnt          <= cnt_n;
         vsync_q      <= vsync_in;
         frame_tick   <= tick;
         level        <= level_n;
         game_started <= started_n;
         wrap_top     <= wt_n;
         wrap_bottom  <= wb_n;
      end
   end

   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      level_n   = level;
      started_n = game_started;
      wt_n      = 1'b0;
      wb_n      = 1'b0;
      case (state)
         IDLE:  if (start_btn) state_n = ARMED;
         // Wait for release so the start press cannot also trigger a jump.
         ARMED: if (!start_btn) begin
            state_n   = PLAY;
            started_n = 1'b1;
         end
         PLAY: if (tick) begin
            if (y_value < TOP && level < MAXL) begin
               level_n = level + 2'd1;
               wt_n    = 1'b1;
               cnt_n   = HOLD_LD;
               state_n = HOLD;
            end else if (y_value > BOT && level != 2'd0) begin
               level_n = level - 2'd1;
               wb_n    = 1'b1;
               cnt_n   = HOLD_LD;
               state_n = HOLD;
            end
         end
         HOLD: if (tick) begin
            // A zero count also exits, so HOLDOFF_FRAMES=0 still skips one frame.
            if (cnt <= CW'(1)) state_n = PLAY;
            if (cnt != '0)     cnt_n   = cnt - CW'(1);
         end
         default: state_n = IDLE;
      endcase
`ifdef LEVEL_DEBUG_EN
      if (skip_rise) begin
         if (state == IDLE || state == ARMED) begin
            state_n   = PLAY;
            started_n = 1'b1;
         end else if (level < MAXL) begin
            level_n = level + 2'd1;
            wt_n    = 1'b1;
            wb_n    = 1'b0;
         end
      end
`endif
   end

endmodule

// File: tb/tb_level_ctrl.sv
// Scoreboard bench for level_ctrl: frame-level reference model feeds a queue, monitor checks on frame_tick.
module tb_level_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        vsync_in;
   logic        start_btn;
   logic [11:0] y_value;
   logic [1:0]  level;
   logic        game_started, wrap_top, wrap_bottom, frame_tick;

   level_ctrl dut (
      .clk(clk), .rst(rst), .vsync_in(vsync_in), .start_btn(start_btn),
      .y_value(y_value), .level(level), .game_started(game_started),
      .wrap_top(wrap_top), .wrap_bottom(wrap_bottom), .frame_tick(frame_tick)
   );

   always #5 clk = ~clk;

   typedef struct {
      int lvl;
      int wt;
      int wb;
      int st;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   // Reference model state, in frames rather than FSM states.
   int m_level   = 0;
   int m_started = 0;
   int m_hold    = 0;

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
      end
   endtask

   task automatic model_frame(input int y);
      exp_t e;
      e.wt = 0;
      e.wb = 0;
      if (m_started != 0) begin
         if (m_hold > 0) m_hold--;
         else if (y < 4 && m_level < 3) begin
            m_level++; e.wt = 1; m_hold = 8;
         end else if (y > 760 && m_level > 0) begin
            m_level--; e.wb = 1; m_hold = 8;
         end
      end
      e.lvl = m_level;
      e.st  = m_started;
      exp_q.push_back(e);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (frame_tick === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_frame_tick", 1, 0);
         end else begin
            e = exp_q.pop_front();
            chk("level", int'(level), e.lvl);
            chk("wrap_top", int'(wrap_top), e.wt);
            chk("wrap_bottom", int'(wrap_bottom), e.wb);
            chk("game_started", int'(game_started), e.st);
         end
      end else if (wrap_top === 1'b1 || wrap_bottom === 1'b1) begin
         chk("stray_wrap_pulse", 1, 0);
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_frame(input int y);
      y_value  = 12'(y);
      vsync_in = 1'b1;
      model_frame(y);
      step(1);
      // y_value is only sampled on the tick cycle; scramble it afterwards.
      y_value = 12'($urandom);
      step(2);
      vsync_in = 1'b0;
      step(3);
   endtask

   task automatic do_start();
      start_btn = 1'b1;
      step(3);
      chk("started_while_pressed", int'(game_started), 0);
      chk("level_while_pressed", int'(level), 0);
      start_btn = 1'b0;
      step(1);
      chk("started_after_release", int'(game_started), 1);
      chk("level_after_start", int'(level), 0);
      m_started = 1;
   endtask

   function automatic int rand_y();
      int b;
      int edge_v[4] = '{3, 4, 760, 761};
      b = int'($urandom_range(0, 5));
      case (b)
         0:       return int'($urandom_range(0, 3));
         1:       return int'($urandom_range(761, 4095));
         2:       return edge_v[$urandom_range(0, 3)];
         default: return int'($urandom_range(4, 760));
      endcase
   endfunction

   initial begin
      rst = 1'b1; vsync_in = 1'b0; start_btn = 1'b0; y_value = 12'd400;
      step(5);
      rst = 1'b0;
      chk("rst_level", int'(level), 0);
      chk("rst_started", int'(game_started), 0);
      chk("rst_wrap_top", int'(wrap_top), 0);
      chk("rst_wrap_bottom", int'(wrap_bottom), 0);
      chk("rst_frame_tick", int'(frame_tick), 0);

      do_frame(2);                      // no effect before start
      do_start();
      do_frame(2);                      // up to 1
      repeat (8) do_frame(2);           // holdoff
      do_frame(2);                      // up to 2
      repeat (8) do_frame(400);
      do_frame(761);                    // down to 1
      repeat (8) do_frame(400);
      do_frame(760);                    // strict compare, no change
      do_frame(0);                      // up to 2
      repeat (8) do_frame(400);
      do_frame(1);                      // up to 3
      repeat (8) do_frame(400);
      do_frame(0);                      // saturated at 3
      do_frame(3);
      do_frame(765);                    // down to 2
      repeat (8) do_frame(400);
      do_frame(765);                    // down to 1
      repeat (8) do_frame(400);
      do_frame(765);                    // down to 0
      repeat (8) do_frame(400);
      do_frame(765);                    // saturated at 0
      do_frame(4095);

      // Reset in the middle of a holdoff window.
      do_frame(2);
      do_frame(400);
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      chk("midhold_rst_level", int'(level), 0);
      chk("midhold_rst_started", int'(game_started), 0);
      chk("midhold_rst_wrap_top", int'(wrap_top), 0);
      chk("midhold_rst_frame_tick", int'(frame_tick), 0);
      m_level = 0; m_started = 0; m_hold = 0;
      do_frame(2);                      // ignored until start repeats
      do_frame(2);
      do_start();

      for (int i = 0; i < 250; i++) do_frame(rand_y());

      step(4);
      chk("scoreboard_drained", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
